alg_nn_ctrl: RTL and testbench
==============================

Name: alg_nn_ctrl

Overview:
Parametrised, registered successor of the analog-PLL neural-net step-decision block. It low-pass filters the phase-count sample n and the gain sample kp. The filtered values go out to the external neural-net threshold generator, which returns k_lo and k_hi. The block then issues a direction decision with a hold-off filter and integrates it into a saturating control word that drives the oscillator tuning DAC.

Parameters:
N_W, 4, width of n
KP_W, 8, width of kp, k_lo, k_hi, avg_kp
INC_W, 8, width of signed step output inc
CW_W, 12, width of control word cw
AVG_SH, 2, IIR shift; filter weight 1/2^AVG_SH
N_LO, 3, lower decision count; upper count N_HI = N_LO+1
HOLD, 2, consecutive equal raw decisions needed to commit (>=1)
CW_RST, 12'h800, cw reset value
MAX_STEP, 8, max step magnitude, power of 2, <= 2^(INC_W-2); used only with ADAPT_STEP_EN

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  n/kp/k_lo/k_hi valid this cycle
n  input  N_W  phase count sample, unsigned
kp  input  KP_W  gain sample, unsigned
k_lo  input  KP_W  NN threshold for n==N_HI, unsigned
k_hi  input  KP_W  NN threshold for n==N_LO, unsigned
avg_n  output  N_W  filtered n, to NN
avg_kp  output  KP_W  filtered kp, to NN
out_valid  output  1  one-cycle pulse; inc/cw updated
inc  output  INC_W  signed step: +step, -step or 0
cw  output  CW_W  saturating control word

Behaviour:
- Reset (rst=1 at an edge) clears everything and overrides in_valid:
  - avg_n=0, avg_kp=0, out_valid=0, inc=0, cw=CW_RST.
  - Internal state: accumulators acc_n and acc_kp=0, run_cnt=0, last_dir=0, step=1.
- All inputs are sampled only on cycles with in_valid=1. Idle cycles hold all state; out_valid=0 on idle cycles.
- IIR filter, per valid sample:
  - Accumulator width is W+AVG_SH: acc <= acc - (acc>>AVG_SH) + x.
  - avg = acc>>AVG_SH, registered, truncating.
  - No overflow is possible; the steady state is x<<AVG_SH.
- Raw decision, combinational on the current sample (unsigned compares):
  - up = (n==N_LO && kp<k_hi) || (n==N_HI && kp<k_lo) || (n<N_LO).
  - Otherwise down. This includes n>N_HI, and kp==threshold gives down.
- Hold-off, per valid sample:
  - If up==last_dir and run_cnt!=0: run_cnt <= min(run_cnt+1, HOLD).
  - Otherwise: run_cnt <= 1 and last_dir <= up.
  - The sample is committed when the updated run_cnt >= HOLD.
- Output, at the edge after the valid sample (latency 1):
  - out_valid=1.
  - inc = committed ? (up ? +step : -step) : 0, two's complement INC_W. With default step 1, up gives 8'h01 and down gives 8'hFF.
  - cw <= cw + sign-extended inc, saturated to [0, 2^CW_W-1]. There is no wrap-around.
- Back-to-back valid samples are allowed, one decision per cycle. Mid-run reset discards any partial run.
- k_lo/k_hi are not registered. The NN path (avg_* to k_*) must close within the same cycle as the next sample.

Optional Feature:
ALG_NN_ADAPT_STEP_EN.
- Defined:
  - On each committed sample in the same direction as the previous committed sample, step <= min(2*step, MAX_STEP). The doubled step applies to the next committed sample.
  - A direction change resets step to 1 and uses 1 immediately.
  - A non-committed sample resets step to 1.
- Undefined: step is constant 1 and MAX_STEP is ignored.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1, n=0 -> out_valid=0, inc=0, cw=12'h800, avg_n=0, avg_kp=0.
2. n=1 valid 3 consecutive cycles (HOLD=2) -> inc=0, 8'h01, 8'h01; cw=800, 801, 802; out_valid pulses each cycle after a sample.
3. n=3, k_hi=20: kp=10 x2 -> second inc=8'h01. Then kp=20 x2 -> inc=0, then 8'hFF. n=4, k_lo=15, kp=14 x2 -> 0, 8'h01. n=9 x2 -> 0, 8'hFF.
4. IIR: constant n=12 from reset, 3 samples -> acc_n=12, 21, 28; avg_n=3, 5, 7. Idle cycles between samples leave avg_n unchanged.
5. Saturation: drive up until cw=12'hFFF, one more committed up -> cw stays 12'hFFF. Same at 0 with down. Alternating up/down every sample -> inc=0 throughout.
6. With ALG_NN_ADAPT_STEP_EN, n=1 x6 -> inc=0, 1, 2, 4, 8, 8. Then n=9 x2 -> 0, 8'hFF. Mid-run rst -> next sample gives inc=0.

Source files
------------

// File: rtl/alg_nn_ctrl_if.sv
// Sample/decision bus for alg_nn_ctrl.
// The master drives the samples and NN thresholds; the slave returns the filtered values and the tuning word.
interface alg_nn_ctrl_if #(
    parameter int N_W   = 4,
    parameter int KP_W  = 8,
    parameter int INC_W = 8,
    parameter int CW_W  = 12
);
    logic             in_valid;
    logic [N_W-1:0]   n;
    logic [KP_W-1:0]  kp;
    logic [KP_W-1:0]  k_lo;
    logic [KP_W-1:0]  k_hi;
    logic [N_W-1:0]   avg_n;
    logic [KP_W-1:0]  avg_kp;
    logic             out_valid;
    logic [INC_W-1:0] inc;
    logic [CW_W-1:0]  cw;

    modport master (
        output in_valid, n, kp, k_lo, k_hi,
        input  avg_n, avg_kp, out_valid, inc, cw
    );

    modport slave (
        input  in_valid, n, kp, k_lo, k_hi,
        output avg_n, avg_kp, out_valid, inc, cw
    );
endinterface

// File: rtl/alg_nn_ctrl.sv
// PLL neural-net step-decision block: IIR pre-filter, thresholded direction with hold-off, saturating control word.
// Optional macro ALG_NN_ADAPT_STEP_EN enables step doubling on repeated same-direction commits.
module alg_nn_ctrl #(
    parameter int             N_W      = 4,
    parameter int             KP_W     = 8,
    parameter int             INC_W    = 8,
    parameter int             CW_W     = 12,
    parameter int             AVG_SH   = 2,
    parameter int             N_LO     = 3,
    parameter int             HOLD     = 2,
    parameter logic [CW_W-1:0] CW_RST  = 12'h800,
    parameter int             MAX_STEP = 8
) (
    input logic         clk,
    input logic         rst,
    alg_nn_ctrl_if.slave bus
);

    localparam int N_HI     = N_LO + 1;
    localparam int ACC_N_W  = N_W + AVG_SH;
    localparam int ACC_KP_W = KP_W + AVG_SH;
    localparam int RUN_W    = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
    localparam int STEP_W   = $clog2(2 * MAX_STEP + 1);
    localparam int SUM_W    = ((CW_W > INC_W) ? CW_W : INC_W) + 2;

    localparam logic signed [SUM_W-1:0] CW_MAX = SUM_W'((64'd1 << CW_W) - 64'd1);

    // Registered state
    logic [ACC_N_W-1:0]      acc_n;
    logic [ACC_KP_W-1:0]     acc_kp;
    logic [N_W-1:0]          avg_n;
    logic [KP_W-1:0]         avg_kp;
    logic                    out_valid;
    logic signed [INC_W-1:0] inc;
    logic [CW_W-1:0]         cw;
    logic [RUN_W-1:0]        run_cnt;
    logic                    last_dir;

    // Next-state values
    logic [ACC_N_W-1:0]      acc_n_nxt;
    logic [ACC_KP_W-1:0]     acc_kp_nxt;
    logic                    up;
    logic [RUN_W-1:0]        run_nxt;
    logic                    last_nxt;
    logic                    committed;
    logic [STEP_W-1:0]       eff_step;
    logic signed [INC_W-1:0] inc_nxt;
    logic signed [SUM_W-1:0] cw_sum;
    logic [CW_W-1:0]         cw_nxt;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can leave it latched.
    always_comb begin
        acc_n_nxt  = acc_n - (acc_n >> AVG_SH) + ACC_N_W'(bus.n);
        acc_kp_nxt = acc_kp - (acc_kp >> AVG_SH) + ACC_KP_W'(bus.kp);
    end

    // Threshold compares; equality with a threshold falls through to down.
    always_comb begin
        up = ((bus.n == N_W'(N_LO)) && (bus.kp < bus.k_hi)) ||
             ((bus.n == N_W'(N_HI)) && (bus.kp < bus.k_lo)) ||
             (bus.n < N_W'(N_LO));
    end

    always_comb begin
        run_nxt  = RUN_W'(1);
        last_nxt = up;
        if ((up == last_dir) && (run_cnt != '0)) begin
            last_nxt = last_dir;
            if (run_cnt >= RUN_W'(HOLD)) begin
                run_nxt = RUN_W'(HOLD);
            end else begin
                run_nxt = run_cnt + RUN_W'(1);
            end
        end
        committed = (run_nxt >= RUN_W'(HOLD));
    end

`ifdef ALG_NN_ADAPT_STEP_EN
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_nxt;
    logic [STEP_W-1:0] step_dbl;
    logic              prev_vld;
    logic              prev_dir;

    // A direction change against the last commit restarts at 1 immediately.
    always_comb begin
        eff_step = step;
        if (prev_vld && (prev_dir != up)) begin
            eff_step = STEP_W'(1);
        end
        step_dbl = eff_step << 1;
        step_nxt = STEP_W'(1);
        if (committed) begin
            step_nxt = (step_dbl > STEP_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : step_dbl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step     <= STEP_W'(1);
            prev_vld <= 1'b0;
            prev_dir <= 1'b0;
        end else if (bus.in_valid) begin
            step <= step_nxt;
            if (committed) begin
                prev_vld <= 1'b1;
                prev_dir <= up;
            end
        end
    end
`else
    assign eff_step = STEP_W'(1);
`endif

    // Sum is formed wide enough that over- and underflow are both visible before clamping.
    always_comb begin
        inc_nxt = '0;
        if (committed) begin
            inc_nxt = up ? INC_W'(eff_step) : -INC_W'(eff_step);
        end
        cw_sum = SUM_W'(signed'({1'b0, cw})) + SUM_W'(inc_nxt);
        if (cw_sum[SUM_W-1]) begin
            cw_nxt = '0;
        end else if (cw_sum > CW_MAX) begin
            cw_nxt = '1;
        end else begin
            cw_nxt = cw_sum[CW_W-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_n     <= '0;
            acc_kp    <= '0;
            avg_n     <= '0;
            avg_kp    <= '0;
            out_valid <= 1'b0;
            inc       <= '0;
            cw        <= CW_RST;
            run_cnt   <= '0;
            last_dir  <= 1'b0;
        end else begin
            out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                acc_n    <= acc_n_nxt;
                acc_kp   <= acc_kp_nxt;
                avg_n    <= acc_n_nxt[ACC_N_W-1:AVG_SH];
                avg_kp   <= acc_kp_nxt[ACC_KP_W-1:AVG_SH];
                inc      <= inc_nxt;
                cw       <= cw_nxt;
                run_cnt  <= run_nxt;
                last_dir <= last_nxt;
            end
        end
    end

    assign bus.avg_n     = avg_n;
    assign bus.avg_kp    = avg_kp;
    assign bus.out_valid = out_valid;
    assign bus.inc       = inc;
    assign bus.cw        = cw;

endmodule

// File: tb/tb_alg_nn_ctrl.sv
// Directed self-checking bench for alg_nn_ctrl with hand-computed expectations.
module tb_alg_nn_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alg_nn_ctrl_if #(.N_W(4), .KP_W(8), .INC_W(8), .CW_W(12)) bus ();

    alg_nn_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [3:0] nv, input logic [7:0] kpv,
                          input logic [7:0] klov, input logic [7:0] khiv);
        bus.in_valid = 1'b1;
        bus.n        = nv;
        bus.kp       = kpv;
        bus.k_lo     = klov;
        bus.k_hi     = khiv;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic sample_chk(input string tag, input logic [3:0] nv, input logic [7:0] kpv,
                              input logic [7:0] klov, input logic [7:0] khiv,
                              input logic [7:0] e_inc, input logic [11:0] e_cw);
        sample(nv, kpv, klov, khiv);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".inc"}, 32'(bus.inc), 32'(e_inc));
        check({tag, ".cw"}, 32'(bus.cw), 32'(e_cw));
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.n        = 4'd0;
        bus.kp       = 8'd0;
        bus.k_lo     = 8'd0;
        bus.k_hi     = 8'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.n        = '0;
        bus.kp       = '0;
        bus.k_lo     = '0;
        bus.k_hi     = '0;

        // Reset with in_valid held high
        do_reset();
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.inc", 32'(bus.inc), 32'd0);
        check("rst.cw", 32'(bus.cw), 32'h800);
        check("rst.avg_n", 32'(bus.avg_n), 32'd0);
        check("rst.avg_kp", 32'(bus.avg_kp), 32'd0);

`ifndef ALG_NN_ADAPT_STEP_EN
        // n below N_LO: hold-off then +1 per sample
        sample_chk("up1", 4'd1, 8'd0, 8'd0, 8'd0, 8'h00, 12'h800);
        sample_chk("up2", 4'd1, 8'd0, 8'd0, 8'd0, 8'h01, 12'h801);
        sample_chk("up3", 4'd1, 8'd0, 8'd0, 8'd0, 8'h01, 12'h802);
        @(posedge clk);
        #1;
        check("idle.out_valid", 32'(bus.out_valid), 32'd0);
        check("idle.cw", 32'(bus.cw), 32'h802);

        // Threshold decisions, including kp equal to a threshold
        do_reset();
        sample_chk("nlo_lt1", 4'd3, 8'd10, 8'd0, 8'd20, 8'h00, 12'h800);
        sample_chk("nlo_lt2", 4'd3, 8'd10, 8'd0, 8'd20, 8'h01, 12'h801);
        sample_chk("nlo_eq1", 4'd3, 8'd20, 8'd0, 8'd20, 8'h00, 12'h801);
        sample_chk("nlo_eq2", 4'd3, 8'd20, 8'd0, 8'd20, 8'hFF, 12'h800);
        sample_chk("nhi_lt1", 4'd4, 8'd14, 8'd15, 8'd0, 8'h00, 12'h800);
        sample_chk("nhi_lt2", 4'd4, 8'd14, 8'd15, 8'd0, 8'h01, 12'h801);
        sample_chk("nbig1", 4'd9, 8'd0, 8'd0, 8'd0, 8'h00, 12'h801);
        sample_chk("nbig2", 4'd9, 8'd0, 8'd0, 8'd0, 8'hFF, 12'h800);
        sample_chk("nhi_eq", 4'd4, 8'd15, 8'd15, 8'd0, 8'hFF, 12'h7FF);
        sample_chk("nsmall1", 4'd2, 8'd255, 8'd0, 8'd0, 8'h00, 12'h7FF);
        sample_chk("nsmall2", 4'd2, 8'd255, 8'd0, 8'd0, 8'h01, 12'h800);

        // IIR filter with an idle gap
        do_reset();
        sample(4'd12, 8'd100, 8'd0, 8'd0);
        check("iir1.avg_n", 32'(bus.avg_n), 32'd3);
        check("iir1.avg_kp", 32'(bus.avg_kp), 32'd25);
        @(posedge clk);
        #1;
        check("iir_idle.avg_n", 32'(bus.avg_n), 32'd3);
        check("iir_idle.out_valid", 32'(bus.out_valid), 32'd0);
        sample(4'd12, 8'd100, 8'd0, 8'd0);
        check("iir2.avg_n", 32'(bus.avg_n), 32'd5);
        check("iir2.avg_kp", 32'(bus.avg_kp), 32'd43);
        sample(4'd12, 8'd100, 8'd0, 8'd0);
        check("iir3.avg_n", 32'(bus.avg_n), 32'd7);
        check("iir3.avg_kp", 32'(bus.avg_kp), 32'd58);

        // Saturation at the top, then at the bottom
        do_reset();
        for (int i = 0; i < 2048; i++) sample(4'd1, 8'd0, 8'd0, 8'd0);
        check("sat_hi.reach", 32'(bus.cw), 32'hFFF);
        sample_chk("sat_hi", 4'd1, 8'd0, 8'd0, 8'd0, 8'h01, 12'hFFF);
        for (int i = 0; i < 4096; i++) sample(4'd9, 8'd0, 8'd0, 8'd0);
        check("sat_lo.reach", 32'(bus.cw), 32'h000);
        sample_chk("sat_lo", 4'd9, 8'd0, 8'd0, 8'd0, 8'hFF, 12'h000);

        // Alternating direction never commits
        for (int i = 0; i < 6; i++) begin
            sample_chk("alt", (i % 2 == 0) ? 4'd1 : 4'd9, 8'd0, 8'd0, 8'd0, 8'h00, 12'h000);
        end
`else
        // Step doubling, capped at MAX_STEP, then a direction change
        sample_chk("ad1", 4'd1, 8'd0, 8'd0, 8'd0, 8'h00, 12'h800);
        sample_chk("ad2", 4'd1, 8'd0, 8'd0, 8'd0, 8'h01, 12'h801);
        sample_chk("ad3", 4'd1, 8'd0, 8'd0, 8'd0, 8'h02, 12'h803);
        sample_chk("ad4", 4'd1, 8'd0, 8'd0, 8'd0, 8'h04, 12'h807);
        sample_chk("ad5", 4'd1, 8'd0, 8'd0, 8'd0, 8'h08, 12'h80F);
        sample_chk("ad6", 4'd1, 8'd0, 8'd0, 8'd0, 8'h08, 12'h817);
        sample_chk("ad_dn1", 4'd9, 8'd0, 8'd0, 8'd0, 8'h00, 12'h817);
        sample_chk("ad_dn2", 4'd9, 8'd0, 8'd0, 8'd0, 8'hFF, 12'h816);
`endif

        // Mid-run reset discards the partial run
        do_reset();
        sample_chk("mr1", 4'd1, 8'd0, 8'd0, 8'd0, 8'h00, 12'h800);
        sample_chk("mr2", 4'd1, 8'd0, 8'd0, 8'd0, 8'h01, 12'h801);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("mr_rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("mr_rst.cw", 32'(bus.cw), 32'h800);
        sample_chk("mr3", 4'd1, 8'd0, 8'd0, 8'd0, 8'h00, 12'h800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
